fp_mult_pipe: RTL

FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

---
 rtl/fp_mult_pipe_pkg.sv | 22 ++
 rtl/fp_mant_mul.sv | 13 +
 rtl/fp_mult_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/fp_mult_pipe_pkg.sv
// fp_mult_pipe_pkg: flag indices, bias, canonical qNaN and field helpers shared by the FP multiplier
package fp_mult_pipe_pkg;
  localparam int FLAG_NAN = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;
  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
  function automatic logic [63:0] qnan(input int ew, input int mw);
    return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
  endfunction
  function automatic logic [63:0] exp_of(input logic [63:0] x, input int ew, input int mw);
    return (x >> mw) & ((64'd1 << ew) - 64'd1);
  endfunction
  function automatic logic [63:0] man_of(input logic [63:0] x, input int mw);
    return x & ((64'd1 << mw) - 64'd1);
  endfunction
  function automatic logic sign_of(input logic [63:0] x, input int ew, input int mw);
    return x[ew + mw];
  endfunction
endpackage

// File: rtl/fp_mant_mul.sv
// fp_mant_mul: registered unsigned significand multiplier with enable
module fp_mant_mul #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           en,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  always_ff @(posedge clk)
    if (en) p <= a * b;
endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 4-stage IEEE-style multiplier (unpack, multiply, normalise/round, pack) with stall handshake
module fp_mult_pipe
  import fp_mult_pipe_pkg::*;
#(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int ROUND_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   prod,
  output logic [3:0]             flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic signed [EW-1:0] BIAS = EW'(bias(EXP_W));
  localparam logic signed [EW-1:0] EOVF = EW'((1 << EXP_W) - 1);
  localparam logic [63:0] QNAN64 = qnan(EXP_W, MAN_W);
  logic en;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  logic [63:0] a64, b64;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic za, zb, ia, ib, na, nb;
  assign a64 = 64'(a);
  assign b64 = 64'(b);
  assign ea = EXP_W'(exp_of(a64, EXP_W, MAN_W));
  assign eb = EXP_W'(exp_of(b64, EXP_W, MAN_W));
  assign fa = MAN_W'(man_of(a64, MAN_W));
  assign fb = MAN_W'(man_of(b64, MAN_W));
  assign za = ea == '0;
  assign zb = eb == '0;
  assign ia = ea == EMAX && fa == '0;
  assign ib = eb == EMAX && fb == '0;
  assign na = ea == EMAX && fa != '0;
  assign nb = eb == EMAX && fb != '0;
  logic v1, v2, v3;
  logic [3:0] m1, m2;
  logic signed [EW-1:0] e1, e2, e3;
  logic [MAN_W:0] ma1, mb1;
  logic [PW-1:0] p2;
  logic s3, nan3, inf3, zero3, inx3;
  logic [MAN_W-1:0] man3;
  // meta = {sign, nan, inf, zero}; subnormals count as zero
  always_ff @(posedge clk)
    if (!rst_n) v1 <= 1'b0;
    else if (en) begin
      v1  <= in_valid;
      m1  <= {sign_of(a64, EXP_W, MAN_W) ^ sign_of(b64, EXP_W, MAN_W),
              na || nb || (ia && zb) || (ib && za), ia || ib, za || zb};
      e1  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
      ma1 <= {1'b1, fa};
      mb1 <= {1'b1, fb};
    end
  fp_mant_mul #(.N(MAN_W + 1)) u_mul (.clk(clk), .en(en), .a(ma1), .b(mb1), .p(p2));
  always_ff @(posedge clk)
    if (!rst_n) v2 <= 1'b0;
    else if (en) begin
      v2 <= v1;
      m2 <= m1;
      e2 <= e1;
    end
  logic [PW-2:0] sh;
  logic [MAN_W-1:0] mt;
  logic guard, sticky, inc;
  logic [MAN_W:0] mr;
  assign sh = p2[PW-1] ? p2[PW-2:0] : {p2[PW-3:0], 1'b0};
  assign mt = sh[PW-2:MAN_W+1];
  assign guard = sh[MAN_W];
  assign sticky = |sh[MAN_W-1:0];
  assign inc = ROUND_EN != 0 && guard && (sticky || mt[0]);
  assign mr = {1'b0, mt} + (MAN_W + 1)'(inc);
  always_ff @(posedge clk)
    if (!rst_n) v3 <= 1'b0;
    else if (en) begin
      v3 <= v2;
      {s3, nan3, inf3, zero3} <= m2;
      e3   <= e2 + EW'(p2[PW-1]) + EW'(mr[MAN_W]);
      man3 <= mr[MAN_W-1:0];
      inx3 <= guard || sticky;
    end
  logic ovf, unf, fin;
  logic [W-1:0] res;
  logic [3:0] fl;
  assign ovf = e3 >= EOVF;
  assign unf = e3[EW-1] || e3 == '0;
  assign fin = !nan3 && !inf3 && !zero3;
  always_comb begin
    fl = '0;
    fl[FLAG_NAN] = nan3;
    fl[FLAG_OVF] = fin && ovf;
    fl[FLAG_UNF] = fin && unf;
    fl[FLAG_INX] = fin && (inx3 || ovf || unf);
    res = nan3 ? W'(QNAN64)
        : (inf3 || (!zero3 && ovf)) ? {s3, EMAX, {MAN_W{1'b0}}}
        : (zero3 || unf) ? {s3, {(EXP_W + MAN_W){1'b0}}}
        : {s3, e3[EXP_W-1:0], man3};
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_valid <= 1'b0;
      prod      <= '0;
      flags     <= '0;
    end else if (en) begin
      out_valid <= v3;
      prod      <= res;
      flags     <= fl;
    end
endmodule
